pe_result_drain: RTL and testbench

PE_RESULT_DRAIN -- requirements
Module: pe_result_drain

---
 rtl/pe_pkg.sv | 13 +
 rtl/pe_vec_fifo.sv | 61 ++++++
 rtl/pe_result_drain.sv | 144 ++++++++++++++
 tb/tb_pe_result_drain.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and default sizes for the PE result drain path.
// No logic; imported by the drain top and its vector FIFO.
package pe_pkg;

    localparam int PE_REG_WIDTH = 16;
    localparam int PE_VECTOR    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } drain_state_t;

endpackage

// File: rtl/pe_vec_fifo.sv
// Purpose: DEPTH-entry FIFO of whole result vectors, with count/full/empty status.
// Latency: a push is visible at dout on the cycle after the write edge.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
module pe_vec_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_result_drain.sv
// Purpose: queue PE result vectors and serialize them one lane per beat (PE_DRAIN_OVF_FLAG_EN adds sticky overflow).
// Latency: first beat valid one cycle after the vector is pushed into an empty FIFO.
// Backpressure: out_ready=0 freezes the beat; pushes into a full FIFO with no pop are dropped.
module pe_result_drain
    import pe_pkg::*;
#(
    parameter int REG_WIDTH = PE_REG_WIDTH,
    parameter int VECTOR    = PE_VECTOR,
    parameter int DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [REG_WIDTH-1:0]        c_ab_in [VECTOR-1:0],
    output logic [REG_WIDTH-1:0]        out_data,
    output logic [$clog2(VECTOR)-1:0]   out_lane,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        fifo_full,
    output logic                        overflow
);
    localparam int                LANE_W    = $clog2(VECTOR);
    localparam int                VEC_W     = REG_WIDTH * VECTOR;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VECTOR - 1);

    drain_state_t         state;
    drain_state_t         state_nxt;
    logic [LANE_W-1:0]    lane;
    logic [LANE_W-1:0]    lane_nxt;
    logic [REG_WIDTH-1:0] hold [VECTOR-1:0];
    logic [VEC_W-1:0]     push_dat;
    logic [VEC_W-1:0]     head_dat;
    logic                 pop;
    logic                 fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 unused_count;

    always_comb begin
        push_dat = '0;
        for (int i = 0; i < VECTOR; i++) begin
            push_dat[i*REG_WIDTH +: REG_WIDTH] = c_ab_in[i];
        end
    end

    pe_vec_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop),
        .din   (push_dat),
        .dout  (head_dat),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Occupancy is exposed by the FIFO for observability; the drain only needs full/empty.
    assign unused_count = ^fifo_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lane  <= '0;
        end else begin
            state <= state_nxt;
            lane  <= lane_nxt;
        end
    end

    // Loading the next vector on the accepted last beat keeps the stream bubble-free.
    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    lane_nxt  = '0;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (lane == LAST_LANE) begin
                        lane_nxt = '0;
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        lane_nxt = lane + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                lane_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VECTOR; i++) begin
                hold[i] <= '0;
            end
        end else if (pop) begin
            for (int i = 0; i < VECTOR; i++) begin
                hold[i] <= head_dat[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign out_valid = (state == EMIT);
    assign out_data  = out_valid ? hold[lane] : '0;
    assign out_lane  = out_valid ? lane : '0;
    assign out_last  = out_valid && (lane == LAST_LANE);

`ifdef PE_DRAIN_OVF_FLAG_EN
    logic drop;
    logic ovf_q;

    assign drop = in_valid && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed scenarios with random payloads, checked each cycle against a queue-based reference model.
module tb_pe_result_drain;
    localparam int RW = 16;
    localparam int V  = 4;
    localparam int D  = 4;
    localparam int LW = 2;
    typedef logic [V*RW-1:0] pvec_t;
`ifdef PE_DRAIN_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [RW-1:0] c_ab_in [V-1:0];
    logic [RW-1:0] out_data;
    logic [LW-1:0] out_lane;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          fifo_full;
    logic          overflow;

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model: queued vectors, the vector being emitted, and the beat streams.
    pvec_t         m_q[$];
    pvec_t         m_hold;
    bit            m_busy;
    int            m_lane;
    bit            m_ovf;
    logic [RW-1:0] exp_beats[$];
    logic [RW-1:0] got_beats[$];
    int            cyc;
    int            first_beat;
    int            last_beat;

    pe_result_drain #(.REG_WIDTH(RW), .VECTOR(V), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .c_ab_in   (c_ab_in),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic pvec_t rv();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hold = '0;
        m_busy = 1'b0;
        m_lane = 0;
        m_ovf  = 1'b0;
        exp_beats.delete();
        got_beats.delete();
    endtask

    task automatic model_edge(input bit iv, input pvec_t d, input bit rdy);
        bit pop;
        bit room;
        room = (m_q.size() < D);
        pop  = (m_q.size() > 0) && (!m_busy || (rdy && m_lane == V-1));
        room = room || pop;
        if (m_busy && rdy) begin
            if (m_lane == V-1) begin
                if (!pop) m_busy = 1'b0;
            end else begin
                m_lane++;
            end
        end
        if (pop) begin
            m_hold = m_q.pop_front();
            m_busy = 1'b1;
            m_lane = 0;
        end
        if (iv) begin
            if (room) begin
                m_q.push_back(d);
                for (int i = 0; i < V; i++) exp_beats.push_back(d[i*RW +: RW]);
            end else begin
                m_ovf = OVF_EN;
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_busy);
        if (m_busy) begin
            chk("out_data", out_data, m_hold[m_lane*RW +: RW]);
            chk("out_lane", out_lane, m_lane);
            chk("out_last", out_last, m_lane == V-1);
        end
        chk("fifo_full", fifo_full, m_q.size() == D);
        chk("overflow", overflow, m_ovf);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit iv, input pvec_t d, input bit rdy);
        in_valid  = iv;
        out_ready = rdy;
        for (int i = 0; i < V; i++) c_ab_in[i] = d[i*RW +: RW];
        if (out_valid === 1'b1 && rdy) begin
            got_beats.push_back(out_data);
            if (got_beats.size() == 1) first_beat = cyc;
            last_beat = cyc;
        end
        @(posedge clk);
        cyc++;
        model_edge(iv, d, rdy);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
    endtask

    task automatic stream_check(input string tag);
        chk({tag, "_len"}, got_beats.size(), exp_beats.size());
        for (int i = 0; i < got_beats.size() && i < exp_beats.size(); i++)
            chk(tag, got_beats[i], exp_beats[i]);
        got_beats.delete();
        exp_beats.delete();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        pvec_t v;
        int    pushed;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < V; i++) c_ab_in[i] = '0;
        cyc = 0;
        first_beat = 0;
        last_beat  = 0;
        model_reset();
        #12;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data",  out_data,  '0);
        chk("rst_lane",  out_lane,  '0);
        chk("rst_last",  out_last,  1'b0);
        chk("rst_full",  fifo_full, 1'b0);
        chk("rst_ovf",   overflow,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single vector {1,2,3,4}: first beat after the edge following the push.
        step(1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
        chk("lat_edge_n", out_valid, 1'b0);
        for (int k = 0; k < V; k++) begin
            step(1'b0, '0, 1'b1);
            chk("single_valid", out_valid, 1'b1);
            chk("single_data", out_data, k + 1);
            chk("single_lane", out_lane, k);
            chk("single_last", out_last, k == V-1);
        end
        step(1'b0, '0, 1'b1);
        chk("single_done", out_valid, 1'b0);
        stream_check("single");

        // Backpressure mid-vector.
        v = rv();
        step(1'b1, v, 1'b1);
        idle(2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, 1'b0);
            chk("bp_lane", out_lane, 1);
            chk("bp_data", out_data, v[RW +: RW]);
        end
        idle(6, 1'b1);
        stream_check("backpressure");

        // Streaming eight vectors as fast as the queue accepts them.
        pushed = 0;
        for (int c = 0; c < 80 && (pushed < 8 || m_busy || m_q.size() > 0); c++) begin
            if (pushed < 8 && m_q.size() < D) begin
                step(1'b1, rv(), 1'b1);
                pushed++;
            end else begin
                step(1'b0, '0, 1'b1);
            end
        end
        idle(1, 1'b1);
        chk("stream_beats", got_beats.size(), 32);
        chk("stream_gapless", last_beat - first_beat, 31);
        chk("stream_noovf", overflow, 1'b0);
        stream_check("stream");

        // Overflow: stalled consumer, six pushes.
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, rv(), 1'b0);
        chk("ovf_full", fifo_full, 1'b1);
        chk("ovf_flag", overflow, OVF_EN);
        chk("ovf_valid", out_valid, 1'b1);
        chk("ovf_lane", out_lane, 0);
        idle(30, 1'b1);
        chk("ovf_beats", got_beats.size(), 20);
        stream_check("overflow");

        // Full FIFO, accepted last beat and a push in the same cycle.
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, rv(), 1'b0);
        idle(3, 1'b1);
        chk("sim_lane", out_lane, V-1);
        step(1'b1, rv(), 1'b1);
        chk("sim_full", fifo_full, 1'b1);
        chk("sim_noovf", overflow, 1'b0);
        chk("sim_lane0", out_lane, 0);
        idle(30, 1'b1);
        chk("sim_beats", got_beats.size(), 24);
        stream_check("simultaneous");

        // Reset during lane 2 with vectors still queued.
        do_reset();
        step(1'b1, rv(), 1'b1);
        step(1'b1, rv(), 1'b1);
        step(1'b1, rv(), 1'b1);
        step(1'b0, '0, 1'b1);
        chk("mid_lane", out_lane, 2);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_full", fifo_full, 1'b0);
        chk("mrst_lane", out_lane, 0);
        chk("mrst_data", out_data, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(6, 1'b1);
        chk("mrst_quiet", out_valid, 1'b0);
        step(1'b1, rv(), 1'b1);
        idle(6, 1'b1);
        stream_check("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
